// File: rtl/seq_substantivo.sv
// seq_substantivo: noun-phrase sequence checker; classifies word codes, counts them and flags well-formed ends or rejections.
module seq_substantivo (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] code_in,
  input  logic       code_valid,
  output logic       code_ready,
  output logic       busy,
  output logic       fim,
  output logic       erro,
  output logic [2:0] state,
  output logic [3:0] cnt_concreto,
  output logic [3:0] cnt_abstrato,
  output logic [3:0] cnt_nomep,
  output logic [4:0] total
);
  typedef enum logic [2:0] {
    IDLE = 3'b000, WAIT = 3'b001, CONC = 3'b010, ABST = 3'b011,
    PROP = 3'b100, DONE = 3'b101, ERR = 3'b110
  } state_t;
  localparam logic [3:0] CONCRETO = 4'b0111;
  localparam logic [3:0] ABSTRATO = 4'b1001;
  localparam logic [3:0] NOMEP    = 4'b1010;
  localparam logic [3:0] NOTA_INV = 4'b1100;
  state_t     r_state;
  logic [3:0] r_cc, r_ca, r_cn, r_tmo;
  logic [4:0] r_tot;
  logic       w_c, w_a, w_n, w_ni, w_acc, w_long;
  state_t     w_adv;
  assign w_c  = code_in == CONCRETO;
  assign w_a  = code_in == ABSTRATO;
  assign w_n  = code_in == NOMEP;
  assign w_ni = code_in == NOTA_INV;
  assign code_ready = r_state inside {WAIT, CONC, ABST, PROP};
  assign busy  = code_ready;
  assign fim   = r_state == DONE;
  assign erro  = r_state == ERR;
  assign state = r_state;
  assign cnt_concreto = r_cc;
  assign cnt_abstrato = r_ca;
  assign cnt_nomep    = r_cn;
  assign total        = r_tot;
  assign w_acc  = code_valid && code_ready;
  // total already at 16 means this word would be the 17th
  assign w_long = (r_tot >= 5'd16) && !w_ni;
  // word order is concrete -> abstract -> proper; anything going backwards is rejected
  always_comb
    w_adv = w_ni ? ((r_state == WAIT) ? ERR : DONE)
          : w_n  ? PROP
          : (w_a && r_state != PROP) ? ABST
          : (w_c && (r_state == WAIT || r_state == CONC)) ? CONC
          : ERR;
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_cc    <= '0;
      r_ca    <= '0;
      r_cn    <= '0;
      r_tot   <= '0;
      r_tmo   <= '0;
    end else if (r_state == IDLE || r_state == ERR) begin
      if (start) begin
        r_state <= WAIT;
        r_cc    <= '0;
        r_ca    <= '0;
        r_cn    <= '0;
        r_tot   <= '0;
        r_tmo   <= '0;
      end
    end else if (r_state == DONE) begin
      r_state <= IDLE;
    end else if (w_acc) begin
      r_state <= w_long ? ERR : w_adv;
      r_tmo   <= '0;
      r_tot   <= (r_tot == 5'd31) ? r_tot : r_tot + 5'd1;
      if (w_c && r_cc != 4'd15) r_cc <= r_cc + 4'd1;
      if (w_a && r_ca != 4'd15) r_ca <= r_ca + 4'd1;
      if (w_n && r_cn != 4'd15) r_cn <= r_cn + 4'd1;
    end else begin
      r_tmo <= r_tmo + 4'd1;
      if (r_tmo == 4'd15) r_state <= ERR;
    end
  end
endmodule

// File: tb/tb_seq_substantivo.sv
// tb_seq_substantivo: directed scoreboard bench for seq_substantivo.
module tb_seq_substantivo;
  logic       clock = 0, reset, start, code_valid;
  logic [3:0] code_in;
  logic       code_ready, busy, fim, erro;
  logic [2:0] state;
  logic [3:0] cnt_concreto, cnt_abstrato, cnt_nomep;
  logic [4:0] total;
  int n_total = 0, n_bad = 0;
  typedef struct {
    logic [2:0] st;
    logic [3:0] cc, ca, cn;
    logic [4:0] tot;
  } exp_t;
  exp_t q[$];
  seq_substantivo dut (
    .clock(clock), .reset(reset), .start(start), .code_in(code_in),
    .code_valid(code_valid), .code_ready(code_ready), .busy(busy),
    .fim(fim), .erro(erro), .state(state), .cnt_concreto(cnt_concreto),
    .cnt_abstrato(cnt_abstrato), .cnt_nomep(cnt_nomep), .total(total)
  );
  always #5 clock = ~clock;
  function automatic exp_t e(input logic [2:0] st, input int cc, input int ca, input int cn, input int tot);
    exp_t x;
    x.st = st; x.cc = 4'(cc); x.ca = 4'(ca); x.cn = 4'(cn); x.tot = 5'(tot);
    return x;
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic step(input logic r, input logic s, input logic v, input logic [3:0] c, input exp_t x);
    exp_t y;
    logic act;
    reset = r; start = s; code_valid = v; code_in = c;
    q.push_back(x);
    @(posedge clock);
    #1;
    y = q.pop_front();
    act = y.st inside {3'd1, 3'd2, 3'd3, 3'd4};
    chk("state", 32'(state), 32'(y.st));
    chk("fim", 32'(fim), 32'(y.st == 3'd5));
    chk("erro", 32'(erro), 32'(y.st == 3'd6));
    chk("busy", 32'(busy), 32'(act));
    chk("ready", 32'(code_ready), 32'(act));
    chk("cnt_concreto", 32'(cnt_concreto), 32'(y.cc));
    chk("cnt_abstrato", 32'(cnt_abstrato), 32'(y.ca));
    chk("cnt_nomep", 32'(cnt_nomep), 32'(y.cn));
    chk("total", 32'(total), 32'(y.tot));
  endtask
  initial begin
    reset = 1; start = 0; code_valid = 0; code_in = 0;
    #1;
    step(1, 0, 0, 4'h0, e(0, 0, 0, 0, 0));
    // well-formed phrase, start ignored in DONE
    step(0, 1, 0, 4'h0, e(1, 0, 0, 0, 0));
    step(0, 0, 1, 4'b0111, e(2, 1, 0, 0, 1));
    step(0, 0, 1, 4'b0111, e(2, 2, 0, 0, 2));
    step(0, 0, 1, 4'b1010, e(4, 2, 0, 1, 3));
    step(0, 0, 1, 4'b1100, e(5, 2, 0, 1, 4));
    step(0, 1, 0, 4'h0, e(0, 2, 0, 1, 4));
    step(0, 0, 0, 4'h0, e(0, 2, 0, 1, 4));
    // abstract then concrete is rejected; ERR holds until start
    step(0, 1, 0, 4'h0, e(1, 0, 0, 0, 0));
    step(0, 0, 1, 4'b1001, e(3, 0, 1, 0, 1));
    step(0, 0, 1, 4'b0111, e(6, 1, 1, 0, 2));
    step(0, 0, 1, 4'b0111, e(6, 1, 1, 0, 2));
    step(0, 1, 0, 4'h0, e(1, 0, 0, 0, 0));
    // start while busy ignored, then empty phrase
    step(0, 1, 0, 4'h0, e(1, 0, 0, 0, 0));
    step(0, 0, 1, 4'b1100, e(6, 0, 0, 0, 1));
    step(0, 0, 0, 4'h0, e(6, 0, 0, 0, 1));
    // timeout expiry
    step(0, 1, 0, 4'h0, e(1, 0, 0, 0, 0));
    for (int i = 0; i < 15; i++) step(0, 0, 0, 4'h0, e(1, 0, 0, 0, 0));
    step(0, 0, 0, 4'h0, e(6, 0, 0, 0, 0));
    // acceptance on the expiry cycle wins and clears the timeout
    step(0, 1, 0, 4'h0, e(1, 0, 0, 0, 0));
    for (int i = 0; i < 15; i++) step(0, 0, 0, 4'h0, e(1, 0, 0, 0, 0));
    step(0, 0, 1, 4'b0111, e(2, 1, 0, 0, 1));
    for (int i = 0; i < 15; i++) step(0, 0, 0, 4'h0, e(2, 1, 0, 0, 1));
    step(0, 0, 1, 4'b1100, e(5, 1, 0, 0, 2));
    step(0, 0, 0, 4'h0, e(0, 1, 0, 0, 2));
    // length limit and counter saturation
    step(0, 1, 0, 4'h0, e(1, 0, 0, 0, 0));
    for (int i = 1; i <= 16; i++) step(0, 0, 1, 4'b0111, e(2, (i > 15) ? 15 : i, 0, 0, i));
    step(0, 0, 1, 4'b0111, e(6, 15, 0, 0, 17));
    // illegal code, then reset mid-sequence wins over start and acceptance
    step(0, 1, 0, 4'h0, e(1, 0, 0, 0, 0));
    step(0, 0, 1, 4'b0011, e(6, 0, 0, 0, 1));
    step(0, 1, 0, 4'h0, e(1, 0, 0, 0, 0));
    step(0, 0, 1, 4'b1010, e(4, 0, 0, 1, 1));
    step(0, 1, 1, 4'b1010, e(4, 0, 0, 2, 2));
    step(1, 1, 1, 4'b1100, e(0, 0, 0, 0, 0));
    step(0, 0, 0, 4'h0, e(0, 0, 0, 0, 0));
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/seq_substantivo.md
SEQ_SUBSTANTIVO -- requirements
Module: seq_substantivo

Interface
- REQ-001: The block SHALL have the port clock, input, 1 bit: the single rising-edge clock.
- REQ-002: The block SHALL have the port reset, input, 1 bit: synchronous, active-high reset.
- REQ-003: The block SHALL have the port start, input, 1 bit: begin a new phrase sequence.
- REQ-004: The block SHALL have the port code_in, input, 4 bits: word-class code {a,b,c,d}.
- REQ-005: The block SHALL have the port code_valid, input, 1 bit: code_in is valid this cycle.
- REQ-006: The block SHALL have the port code_ready, output, 1 bit: the block can accept a code this cycle.
- REQ-007: The block SHALL have the port busy, output, 1 bit: a sequence is in progress.
- REQ-008: The block SHALL have the port fim, output, 1 bit: one-cycle pulse marking a well-formed phrase end.
- REQ-009: The block SHALL have the port erro, output, 1 bit: level; the sequence was rejected.
- REQ-010: The block SHALL have the port state, output, 3 bits: current FSM state encoding.
- REQ-011: The block SHALL have the ports cnt_concreto, cnt_abstrato and cnt_nomep, outputs, 4 bits each: per-class accepted-word counts.
- REQ-012: The block SHALL have the port total, output, 5 bits: total accepted words, including the terminator.
- REQ-013: The block SHALL use these code constants: CONCRETO=4'b0111, ABSTRATO=4'b1001, NOMEP=4'b1010, NOTA_INV=4'b1100. Any other value is ILLEGAL.
- REQ-014: The block SHALL use these state encodings: IDLE=000, WAIT=001, CONC=010, ABST=011, PROP=100, DONE=101, ERR=110.

Function
- REQ-015: A code SHALL be accepted only on a cycle where code_valid=1 and code_ready=1.
- REQ-016: The state and counter update SHALL take effect at the next rising edge (1-cycle latency).
- REQ-017: code_ready SHALL be 1 exactly in WAIT, CONC, ABST and PROP, combinationally from state.
- REQ-018: busy SHALL be 1 in WAIT, CONC, ABST and PROP, and 0 in IDLE, DONE and ERR.
- REQ-019: In IDLE, start=1 SHALL go to WAIT and clear all counters and the timeout counter.
- REQ-020: In ERR, start=1 SHALL go to WAIT, clear erro and clear all counters; without start, the block SHALL stay in ERR.
- REQ-021: start SHALL be ignored while busy=1 or in DONE.
- REQ-022: In WAIT, acceptance SHALL transition as follows: CONCRETO->CONC, ABSTRATO->ABST, NOMEP->PROP, NOTA_INV->ERR (empty phrase), ILLEGAL->ERR.
- REQ-023: In CONC, acceptance SHALL transition as follows: CONCRETO->CONC, ABSTRATO->ABST, NOMEP->PROP, NOTA_INV->DONE, ILLEGAL->ERR.
- REQ-024: In ABST, acceptance SHALL transition as follows: ABSTRATO->ABST, NOMEP->PROP, NOTA_INV->DONE, CONCRETO->ERR, ILLEGAL->ERR.
- REQ-025: In PROP, acceptance SHALL transition as follows: NOMEP->PROP, NOTA_INV->DONE, CONCRETO/ABSTRATO->ERR, ILLEGAL->ERR.
- REQ-026: DONE SHALL last exactly one cycle and then go unconditionally to IDLE.
- REQ-027: fim SHALL be 1 exactly while state==DONE.
- REQ-028: erro SHALL be 1 exactly while state==ERR.
- REQ-029: On each accepted CONCRETO, ABSTRATO or NOMEP, the matching cnt_* SHALL increment, saturating at 15.
- REQ-030: Every accepted code, including NOTA_INV and ILLEGAL, SHALL increment total, saturating at 31.
- REQ-031: If an accepted code would make total exceed 16 and the code is not NOTA_INV, the block SHALL go to ERR (phrase too long) and the counters SHALL still update.
- REQ-032: A 4-bit timeout counter SHALL increment on every busy cycle without an acceptance and SHALL clear on acceptance.
- REQ-033: When the timeout counter reaches 15 with no acceptance in that cycle, the block SHALL go to ERR on the next edge.
- REQ-034: If acceptance and timeout expiry occur in the same cycle, acceptance SHALL win.
- REQ-035: Counters SHALL hold their values through DONE, IDLE and ERR until the next start.
- REQ-036: code_in SHALL be ignored when code_valid=0; code_valid SHALL be ignored when code_ready=0.

Reset
- REQ-037: When reset=1 at a rising edge, the block SHALL set state=IDLE, all counters=0, timeout counter=0, fim=0, erro=0, busy=0 and code_ready=0.
- REQ-038: Reset SHALL take priority over start and code acceptance in the same cycle.
- REQ-039: Reset mid-sequence SHALL abort the sequence with no fim pulse.

Verification
- REQ-040: The bench SHALL cover: start; 0111, 0111, 1010, 1100 at one per cycle -> fim=1 one cycle after the 1100 acceptance; cnt_concreto=2, cnt_nomep=1, total=4; then IDLE.
- REQ-041: The bench SHALL cover: start; 1001, then 0111 -> erro=1, state=110; cnt_abstrato=1, cnt_concreto=1, total=2; a following start -> WAIT with counters=0.
- REQ-042: The bench SHALL cover: start; 1100 first -> ERR (empty phrase), total=1, no fim.
- REQ-043: The bench SHALL cover: start, then no code_valid for 15 cycles -> ERR on the 16th edge; a variant with code_valid on cycle 15 -> acceptance wins and the timeout clears.
- REQ-044: The bench SHALL cover: start; 16 consecutive 0111 codes -> the 16th keeps the state in CONC and cnt_concreto saturates at 15; a 17th 0111 -> ERR, total=17.
- REQ-045: The bench SHALL cover: reset asserted in PROP with code_valid=1 -> next cycle state=000, all outputs 0, no fim; start asserted during busy -> no effect.
